// File: rtl/imem_fetch_sequencer.sv
// Fetch sequencer for the word-indexed, async-read instruction memory.
// Owns the PC, drives the memory address, and registers each fetched word
// into a one-entry valid/ready slot for decode. Handles branch redirect,
// stall, halt on HLT, end-of-memory stop and out-of-range branch fault.
//
// Ports:
//   CLK, RESET_n          clock, synchronous active-low reset
//   Start                 begin/restart fetch at RESET_PC (IDLE, HALT, FAULT)
//   Stall                 freeze fetch; a ready decode still drains the slot
//   BranchTaken/Target    one-cycle redirect to a word index
//   ImemAddress/ImemData  instruction memory address (== PC) and read data
//   Instr/InstrPC/Valid   output slot towards decode
//   InstrReady            decode accepts the slot this cycle
//   PC                    current fetch PC
//   Halted, Fault         state flags
//   FetchCount            words latched since Start, saturating
module imem_fetch_sequencer #(
  parameter int unsigned            BITSIZE   = 32,
  parameter int unsigned            REGSIZE   = 64,
  parameter int unsigned            MEMDEPTH  = 64,
  parameter logic [REGSIZE-1:0]     RESET_PC  = '0,
  parameter logic [BITSIZE-1:0]     HALT_WORD = BITSIZE'(32'hD4400000)
) (
  input  logic               CLK,
  input  logic               RESET_n,
  input  logic               Start,
  input  logic               Stall,
  input  logic               BranchTaken,
  input  logic [REGSIZE-1:0] BranchTarget,
  output logic [REGSIZE-1:0] ImemAddress,
  input  logic [BITSIZE-1:0] ImemData,
  output logic [BITSIZE-1:0] Instr,
  output logic [REGSIZE-1:0] InstrPC,
  output logic               InstrValid,
  input  logic               InstrReady,
  output logic [REGSIZE-1:0] PC,
  output logic               Halted,
  output logic               Fault,
  output logic [15:0]        FetchCount
);

  localparam int unsigned       CNTW    = 16;
  localparam logic [REGSIZE-1:0] DEPTH   = REGSIZE'(MEMDEPTH);
  localparam logic [REGSIZE-1:0] LAST_PC = REGSIZE'(MEMDEPTH - 1);
  localparam logic [CNTW-1:0]   CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t             state_q;
  logic [REGSIZE-1:0] pc_q;
  logic [BITSIZE-1:0] instr_q;
  logic [REGSIZE-1:0] instr_pc_q;
  logic               valid_q;
  logic               halted_q;
  logic               fault_q;
  logic [CNTW-1:0]    cnt_q;

  logic [CNTW-1:0]    cnt_d;
  logic               slot_free;
  logic               stop_here;

  // Saturating fetch counter increment.
  assign cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNTW'(1);
  // Slot can take a new word when empty or being consumed this cycle.
  assign slot_free = !valid_q || InstrReady;
  // Word being latched ends the run: HLT encoding or last memory word.
  assign stop_here = (ImemData == HALT_WORD) || (pc_q == LAST_PC);

  // Sequencer state machine with registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            valid_q <= 1'b0;
          end
        end

        S_FETCH: begin
          if (BranchTaken) begin
            // Redirect flushes the slot; an out-of-range target faults
            // without moving the PC so the address stays in range.
            valid_q <= 1'b0;
            if (BranchTarget >= DEPTH) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end else begin
              pc_q <= BranchTarget;
            end
          end else if (Stall) begin
            if (InstrReady) begin
              valid_q <= 1'b0;
            end
          end else if (slot_free) begin
            instr_q    <= ImemData;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
            cnt_q      <= cnt_d;
            if (stop_here) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_q + REGSIZE'(1);
            end
          end
        end

        S_HALT, S_FAULT: begin
          if (Start) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
          end else if (InstrReady) begin
            // Final word stays offered until decode takes it.
            valid_q <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ImemAddress = pc_q;
  assign PC          = pc_q;
  assign Instr       = instr_q;
  assign InstrPC     = instr_pc_q;
  assign InstrValid  = valid_q;
  assign Halted      = halted_q;
  assign Fault       = fault_q;
  assign FetchCount  = cnt_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the fetch rules.
module tb_imem_fetch_sequencer;

  localparam logic [31:0] HLT = 32'hD4400000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        br;
  logic [63:0] tgt;
  logic [63:0] addr;
  logic [31:0] idata;
  logic [31:0] instr;
  logic [63:0] ipc;
  logic        ivalid;
  logic        ready;
  logic [63:0] pc;
  logic        halted;
  logic        fault;
  logic [15:0] fcnt;

  logic [31:0] mem [64];

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Model state: 0 idle, 1 fetching, 2 halted, 3 faulted.
  int          m_st;
  logic [63:0] m_pc;
  logic [63:0] m_ipc;
  logic [31:0] m_instr;
  bit          m_valid;
  int          m_cnt;

  imem_fetch_sequencer dut (
    .CLK          (clk),
    .RESET_n      (rst_n),
    .Start        (start),
    .Stall        (stall),
    .BranchTaken  (br),
    .BranchTarget (tgt),
    .ImemAddress  (addr),
    .ImemData     (idata),
    .Instr        (instr),
    .InstrPC      (ipc),
    .InstrValid   (ivalid),
    .InstrReady   (ready),
    .PC           (pc),
    .Halted       (halted),
    .Fault        (fault),
    .FetchCount   (fcnt)
  );

  // Async-read instruction memory.
  assign idata = (addr < 64'd64) ? mem[addr[5:0]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock edge of the fetch rules, applied to the model.
  task automatic m_step();
    logic [31:0] w;
    if (!rst_n) begin
      m_st = 0; m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_cnt = 0;
      return;
    end
    case (m_st)
      0: if (start) begin m_st = 1; m_pc = 0; m_cnt = 0; m_valid = 0; end
      1: begin
        if (br) begin
          m_valid = 0;
          if (tgt >= 64'd64) m_st = 3;
          else m_pc = tgt;
        end else if (stall) begin
          if (ready) m_valid = 0;
        end else if (!m_valid || ready) begin
          w = mem[m_pc[5:0]];
          m_instr = w;
          m_ipc = m_pc;
          m_valid = 1;
          if (m_cnt < 65535) m_cnt++;
          if (w == HLT || m_pc == 64'd63) m_st = 2;
          else m_pc = m_pc + 64'd1;
        end
      end
      default: begin
        if (start) begin m_st = 1; m_pc = 0; m_valid = 0; m_cnt = 0; end
        else if (ready) m_valid = 0;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #2;
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HLT) w = w ^ 32'h1;
    return w;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("InstrValid", 64'(ivalid), 64'(m_valid));
      cmp("PC", pc, m_pc);
      cmp("ImemAddress", addr, m_pc);
      cmp("AddrInRange", 64'(addr < 64'd64), 64'd1);
      cmp("Halted", 64'(halted), 64'(m_st == 2));
      cmp("Fault", 64'(fault), 64'(m_st == 3));
      cmp("FetchCount", 64'(fcnt), 64'(m_cnt));
      if (m_valid) begin
        cmp("Instr", 64'(instr), 64'(m_instr));
        cmp("InstrPC", ipc, m_ipc);
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; br = 1'b0; tgt = '0; ready = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = rnd_word();
    mem[0] = 32'hF2800040;
    mem[1] = 32'hF2A00081;
    mem[2] = 32'h8B020020;
    mem[3] = HLT;

    // Reset
    tick();
    chk_en = 1;
    tick();
    cmp("RST_InstrValid", 64'(ivalid), 64'd0);
    cmp("RST_PC", pc, 64'd0);
    cmp("RST_FetchCount", 64'(fcnt), 64'd0);
    cmp("RST_Halted", 64'(halted), 64'd0);
    cmp("RST_Fault", 64'(fault), 64'd0);
    rst_n = 1'b1;

    // T1: straight-line run into HLT
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cmp("T1_InstrPC", ipc, 64'(i));
      cmp("T1_Valid", 64'(ivalid), 64'd1);
    end
    cmp("T1_Halted", 64'(halted), 64'd1);
    cmp("T1_FetchCount", 64'(fcnt), 64'd4);
    cmp("T1_PC", pc, 64'd3);
    tick();
    cmp("T1_Drained", 64'(ivalid), 64'd0);

    // T2: decode back-pressure
    start = 1'b1; tick(); start = 1'b0;
    tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("T2_Instr", 64'(instr), 64'h00000000F2800040);
      cmp("T2_PC", pc, 64'd1);
      cmp("T2_FetchCount", 64'(fcnt), 64'd1);
    end
    ready = 1'b1;
    tick();
    cmp("T2_InstrPC", ipc, 64'd1);
    cmp("T2_FetchCount2", 64'(fcnt), 64'd2);

    // T3: branch beats stall and a HLT at the current PC
    mem[2] = HLT;
    br = 1'b1; tgt = 64'd10; stall = 1'b1;
    tick();
    br = 1'b0; stall = 1'b0;
    cmp("T3_Valid", 64'(ivalid), 64'd0);
    cmp("T3_PC", pc, 64'd10);
    cmp("T3_Halted", 64'(halted), 64'd0);
    tick();
    cmp("T3_InstrPC", ipc, 64'd10);

    // T4: out-of-range branch target
    br = 1'b1; tgt = 64'd64;
    tick();
    br = 1'b0;
    cmp("T4_Fault", 64'(fault), 64'd1);
    cmp("T4_Valid", 64'(ivalid), 64'd0);
    cmp("T4_PC", pc, 64'd11);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    cmp("T4_FaultClr", 64'(fault), 64'd0);
    cmp("T4_PC0", pc, 64'd0);
    tick();
    cmp("T4_InstrPC", ipc, 64'd0);

    // T5: run off the end of memory
    br = 1'b1; tgt = 64'd60;
    tick();
    br = 1'b0;
    for (int i = 60; i < 64; i++) begin
      tick();
      cmp("T5_InstrPC", ipc, 64'(i));
    end
    cmp("T5_Halted", 64'(halted), 64'd1);
    cmp("T5_PC", pc, 64'd63);
    tick();
    cmp("T5_PCHold", pc, 64'd63);

    // T6: reset mid-stream
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    cmp("T6_ValidBefore", 64'(ivalid), 64'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    cmp("T6_Valid", 64'(ivalid), 64'd0);
    cmp("T6_PC", pc, 64'd0);
    cmp("T6_FetchCount", 64'(fcnt), 64'd0);
    cmp("T6_Instr", 64'(instr), 64'd0);
    cmp("T6_InstrPC", ipc, 64'd0);
    tick(); tick();
    cmp("T6_Idle", 64'(ivalid), 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    cmp("T6_Refetch", 64'(ivalid), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(15) == 0) ? HLT : rnd_word();
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(299) != 0);
      start = ($urandom_range(11) == 0);
      stall = ($urandom_range(4) == 0);
      br    = ($urandom_range(9) == 0);
      tgt   = ($urandom_range(7) == 0) ? 64'($urandom_range(200) + 64) : 64'($urandom_range(63));
      ready = ($urandom_range(3) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
